// File: rtl/if_stage_mc_if.sv
// Instruction-memory fetch channel: request/address out, one-cycle ack/data back.
// The fetch stage drives the master side; the memory model drives the slave side.
interface if_stage_mc_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage_mc.sv
// Instruction-fetch stage with IF/ID register: variable-latency fetch, decode freeze,
// and EXE redirect, including a redirect that lands while a fetch is still outstanding.
module if_stage_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_addr,
    if_stage_mc_if.master        imem,
    output logic [31:0]          PC,
    output logic [31:0]          Instruction,
    output logic                 valid
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] if_pc_d, if_instr_d;
    logic        if_valid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc_q + 32'd4;
    // A request is held from the cycle it rises until its ack; only HOLD and reset lower it.
    assign imem.req  = !rst && (state_q != S_HOLD);
    assign imem.addr = pc_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_pc_d      = PC;
        if_instr_d   = Instruction;
        if_valid_d   = valid;

        if (branch_taken) begin
            if_pc_d    = '0;
            if_instr_d = '0;
            if_valid_d = 1'b0;
            case (state_q)
                S_WAIT, S_DRAIN: begin
                    // An ack in the redirect cycle retires the wrong-path fetch at once.
                    if (imem.ack) begin
                        pc_d    = branch_addr;
                        state_d = S_WAIT;
                    end else begin
                        target_d = branch_addr;
                        state_d  = S_DRAIN;
                    end
                end
                S_HOLD: begin
                    pc_d    = branch_addr;
                    state_d = S_WAIT;
                end
                default: state_d = S_WAIT;
            endcase
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (imem.ack) begin
                        pc_d = pc_plus4;
                        if (freeze) begin
                            skid_pc_d    = pc_plus4;
                            skid_instr_d = imem.rdata;
                            state_d      = S_HOLD;
                        end else begin
                            if_pc_d    = pc_plus4;
                            if_instr_d = imem.rdata;
                            if_valid_d = 1'b1;
                        end
                    end else if (!freeze) begin
                        if_instr_d = '0;
                        if_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        if_pc_d    = skid_pc_q;
                        if_instr_d = skid_instr_q;
                        if_valid_d = 1'b1;
                        state_d    = S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (!freeze) begin
                        if_instr_d = '0;
                        if_valid_d = 1'b0;
                    end
                    if (imem.ack) begin
                        pc_d    = target_q;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT;
            pc_q        <= RESET_PC;
            PC          <= '0;
            Instruction <= '0;
            valid       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            PC          <= if_pc_d;
            Instruction <= if_instr_d;
            valid       <= if_valid_d;
        end
    end

    // NOTE: skid and target payloads are not reset; they are only read in HOLD/DRAIN,
    // which reset leaves, so the state register alone encodes "skid empty".
    always_ff @(posedge clk) begin
        target_q     <= target_d;
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

endmodule

// File: tb/tb_if_stage_mc.sv
// Scoreboard bench for if_stage_mc: a transaction-level fetch model predicts delivered
// instructions, a separate monitor compares IF/ID every cycle; a second instance checks PC wrap.
module tb_if_stage_mc;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
    } ifid_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] PC, Instruction;
    logic        valid;
    logic [31:0] w_pc, w_instr;
    logic        w_valid;

    if_stage_mc_if imem ();
    if_stage_mc_if wmem ();

    always #5 clk = ~clk;

    if_stage_mc #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem),
        .PC           (PC),
        .Instruction  (Instruction),
        .valid        (valid)
    );

    if_stage_mc #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .freeze       (1'b0),
        .branch_taken (1'b0),
        .branch_addr  (32'h0),
        .imem         (wmem),
        .PC           (w_pc),
        .Instruction  (w_instr),
        .valid        (w_valid)
    );

    // Zero-wait memory for the wrap instance.
    assign wmem.ack   = wmem.req;
    assign wmem.rdata = wmem.addr ^ KEY;

    int    tests = 0;
    int    fails = 0;
    ifid_t exp_q[$];

    // Fetch model: where the next useful fetch goes, and what is waiting to be delivered.
    logic [31:0] m_fetch;
    logic [31:0] m_target;
    bit          m_parked;
    bit          m_discard;
    ifid_t       m_parked_item;
    int          lat_mode;
    bit          mem_busy;
    int          mem_cnt;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // One clock cycle: drive inputs, play the memory, advance the model.
    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba);
        ifid_t it;
        bit    ak;
        @(posedge clk);
        #2;
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        #1;
        if (r) begin
            mem_busy   = 1'b0;
            imem.ack   = 1'b0;
            imem.rdata = '0;
            check("req_in_reset", {31'd0, imem.req}, 32'd0);
            m_fetch   = RST_PC;
            m_parked  = 1'b0;
            m_discard = 1'b0;
            return;
        end
        check("req_level", {31'd0, imem.req}, {31'd0, !m_parked});
        if (imem.req) check("fetch_addr", imem.addr, m_fetch);

        if (imem.req && !mem_busy) begin
            mem_busy = 1'b1;
            mem_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        if (mem_busy && mem_cnt == 0) begin
            imem.ack   = 1'b1;
            imem.rdata = word_at(imem.addr);
            mem_busy   = 1'b0;
        end else begin
            imem.ack   = 1'b0;
            imem.rdata = $urandom;
            if (mem_busy) mem_cnt--;
        end
        ak = imem.ack;

        if (b) begin
            if (m_parked) begin
                m_parked = 1'b0;
                m_fetch  = ba;
            end else if (ak) begin
                m_discard = 1'b0;
                m_fetch   = ba;
            end else begin
                m_discard = 1'b1;
                m_target  = ba;
            end
        end else if (m_discard) begin
            if (ak) begin
                m_discard = 1'b0;
                m_fetch   = m_target;
            end
        end else if (m_parked) begin
            if (!f) begin
                exp_q.push_back(m_parked_item);
                m_parked = 1'b0;
            end
        end else if (ak) begin
            it.v    = 1'b1;
            it.pc   = m_fetch + 32'd4;
            it.ins  = word_at(m_fetch);
            m_fetch = m_fetch + 32'd4;
            if (f) begin
                m_parked      = 1'b1;
                m_parked_item = it;
            end else begin
                exp_q.push_back(it);
            end
        end
    endtask

    // Monitor: at mid-cycle, compare IF/ID against what the previous cycle's inputs imply.
    initial begin
        ifid_t       e;
        logic [31:0] wn;
        bit          pr, pf, pb;
        int          n;
        e  = '{1'b0, 32'd0, 32'd0};
        wn = WRAP_PC;
        forever begin
            @(posedge clk);
            pr = rst;
            pf = freeze;
            pb = branch_taken;
            n  = exp_q.size();
            #5;
            if (pr || pb) begin
                e = '{1'b0, 32'd0, 32'd0};
            end else if (pf) begin
                e = e;
            end else if (n > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.v   = 1'b0;
                e.ins = '0;
            end
            check("valid", {31'd0, valid}, {31'd0, e.v});
            check("instruction", Instruction, e.ins);
            if (e.v || pr || pb) check("pc_out", PC, e.pc);

            if (pr) begin
                check("wrap_valid_rst", {31'd0, w_valid}, 32'd0);
                check("wrap_pc_rst", w_pc, 32'd0);
                wn = WRAP_PC;
            end else begin
                check("wrap_valid", {31'd0, w_valid}, 32'd1);
                check("wrap_pc", w_pc, wn + 32'd4);
                check("wrap_instr", w_instr, word_at(wn));
                wn = wn + 32'd4;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        imem.ack     = 1'b0;
        imem.rdata   = '0;
        m_fetch      = RST_PC;
        m_target     = '0;
        m_parked     = 1'b0;
        m_discard    = 1'b0;
        mem_busy     = 1'b0;
        mem_cnt      = 0;
        lat_mode     = 0;

        // Zero-wait streaming, then a 3-cycle freeze with an ack landing in it.
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Two-wait memory from reset.
        lat_mode = 2;
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect while a three-wait fetch is outstanding.
        lat_mode = 3;
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (17) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        repeat (12) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect coincident with freeze and ack, then redirect out of HOLD.
        lat_mode = 0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic with occasional mid-fetch resets.
        lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            bit          r, f, b;
            logic [31:0] ba;
            r  = ($urandom_range(0, 499) == 0);
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 11) == 0);
            ba = ($urandom_range(0, 7) == 0) ? 32'($urandom) : ($urandom & 32'h0000_0FFC);
            step(r, f, b, ba);
        end

        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #6;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
